// File: rtl/ws2812b_frame_streamer_if.sv
// ---------------------------------------------------------------------------
// ws2812b_frame_streamer_if
//   Word handshake between the frame streamer and the WS2812B serializer.
//
//   bitstream_available : streamer -> serializer, bitstream holds a valid,
//                         not yet consumed GRB word
//   bitstream[23:0]     : streamer -> serializer, GRB word, bit 23 sent first
//   bitstream_read      : serializer -> streamer, one-cycle "word taken" pulse
//
//   master : streamer side
//   slave  : serializer side
// ---------------------------------------------------------------------------
interface ws2812b_frame_streamer_if;
  logic        bitstream_available;
  logic [23:0] bitstream;
  logic        bitstream_read;

  modport master (
    output bitstream_available,
    output bitstream,
    input  bitstream_read
  );

  modport slave (
    input  bitstream_available,
    input  bitstream,
    output bitstream_read
  );
endinterface

// File: rtl/ws2812b_frame_streamer.sv
// ---------------------------------------------------------------------------
// ws2812b_frame_streamer
//   Frame store plus sequencer feeding the WS2812B serializer. Holds one
//   24-bit GRB word per LED and, on each accepted frame tick, streams all
//   words in LED order over the available/read handshake.
//
// Ports:
//   clk           : system clock
//   resetn        : synchronous active-low reset (frame memory not cleared)
//   wr_en_i       : write strobe, one word per cycle
//   wr_addr_i     : LED index to write; indices >= LEDCOUNT are ignored
//   wr_data_i     : GRB word ([23:16] G, [15:8] R, [7:0] B)
//   frame_tick_i  : one-cycle request to stream a frame
//   stream_if     : word handshake to the serializer (master side)
//   busy_o        : high from frame start until the last word is consumed
//   frame_done_o  : one-cycle pulse after the last word is consumed
//   overrun_o     : one-cycle pulse when a frame tick is dropped
//
// Optional build macro:
//   WS2812B_FRAME_STREAMER_DOUBLE_BUFFER_EN - two memory banks; writes go to
//   the back bank, streaming reads the front bank, banks swap on an accepted
//   frame tick. Without it a single bank is used and mid-frame writes may
//   show up in words not yet fetched.
// ---------------------------------------------------------------------------
module ws2812b_frame_streamer #(
  parameter int LEDCOUNT   = 36,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [23:0]           wr_data_i,
  input  logic                  frame_tick_i,
  ws2812b_frame_streamer_if.master stream_if,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  overrun_o
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PRESENT} state_e;

  // One extra bit so LEDCOUNT == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   LED_COUNT_W = (ADDR_WIDTH+1)'(LEDCOUNT);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(LEDCOUNT - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [23:0]           bitstream_q, bitstream_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overrun_q, overrun_d;
  logic                  tick_accept;
  logic                  wr_ok;
  logic [23:0]           rd_data_q;

  assign wr_ok = wr_en_i && ({1'b0, wr_addr_i} < LED_COUNT_W);

  // -------------------------------------------------------------------------
  // Frame memory: registered read of the current index every cycle, so the
  // word read during FETCH is ready in LOAD. A same-edge write to the same
  // address is not seen by that read (old data returned).
  // -------------------------------------------------------------------------
`ifdef WS2812B_FRAME_STREAMER_DOUBLE_BUFFER_EN
  logic [23:0] mem_q [2][LEDCOUNT];
  logic        front_q, front_d;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[~front_q][wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[front_q][index_q];
  end
`else
  logic [23:0] mem_q [LEDCOUNT];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[index_q];
  end
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      index_q      <= '0;
      bitstream_q  <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef WS2812B_FRAME_STREAMER_DOUBLE_BUFFER_EN
      front_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      bitstream_q  <= bitstream_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
`ifdef WS2812B_FRAME_STREAMER_DOUBLE_BUFFER_EN
      front_q      <= front_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    bitstream_d  = bitstream_q;
    frame_done_d = 1'b0;
`ifdef WS2812B_FRAME_STREAMER_DOUBLE_BUFFER_EN
    front_d      = front_q;
`endif
    // The cycle frame_done is high still belongs to the finished frame, so a
    // tick landing there is treated as arriving while busy.
    tick_accept  = frame_tick_i && (state_q == IDLE) && !frame_done_q;
    overrun_d    = frame_tick_i && !tick_accept;

    case (state_q)
      IDLE: begin
        if (tick_accept) begin
          state_d = FETCH;
          index_d = '0;
`ifdef WS2812B_FRAME_STREAMER_DOUBLE_BUFFER_EN
          front_d = ~front_q;
`endif
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        bitstream_d = rd_data_q;
        state_d     = PRESENT;
      end
      PRESENT: begin
        if (stream_if.bitstream_read) begin
          if (index_q == LAST_IDX) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end else begin
            index_d = index_q + ADDR_WIDTH'(1);
            state_d = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    stream_if.bitstream_available = (state_q == PRESENT);
    stream_if.bitstream           = bitstream_q;
    busy_o                        = (state_q != IDLE);
    frame_done_o                  = frame_done_q;
    overrun_o                     = overrun_q;
  end

endmodule

// File: tb/tb_ws2812b_frame_streamer.sv
// ---------------------------------------------------------------------------
// tb_ws2812b_frame_streamer
//   Directed bench for ws2812b_frame_streamer: LED i holds {i, A5, ~i};
//   frames are consumed by a serializer model that reads each word two
//   cycles after it becomes available.
// ---------------------------------------------------------------------------
module tb_ws2812b_frame_streamer;

  localparam int LEDCOUNT   = 36;
  localparam int ADDR_WIDTH = 6;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [23:0]           wr_data;
  logic                  frame_tick;
  logic                  busy;
  logic                  frame_done;
  logic                  overrun;

  ws2812b_frame_streamer_if s_if ();

  ws2812b_frame_streamer #(
    .LEDCOUNT   (LEDCOUNT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .frame_tick_i (frame_tick),
    .stream_if    (s_if),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Pulse counters sampled on the inactive edge.
  int   fd_cnt    = 0;
  int   ov_cnt    = 0;
  int   start_cnt = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (busy === 1'b1 && busy_prev !== 1'b1) start_cnt++;
    busy_prev = busy;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  function automatic logic [23:0] exp_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, 8'hA5, ~b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [23:0] data);
    wr_en   = 1'b1;
    wr_addr = addr[ADDR_WIDTH-1:0];
    wr_data = data;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic load_all(input int skip);
    for (int i = 0; i < LEDCOUNT; i++) begin
      if (i != skip) write_word(i, exp_word(i));
    end
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic wait_avail(input string tag, output bit ok);
    int n = 0;
    while (s_if.bitstream_available !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    ok = (s_if.bitstream_available === 1'b1);
    if (!ok) check({"timeout_", tag}, 32'd0, 32'd1);
  endtask

  // Serializer model: read the word two cycles after it is first seen.
  task automatic consume_word(input string tag, output logic [23:0] w, output bit ok);
    wait_avail(tag, ok);
    w = s_if.bitstream;
    if (!ok) return;
    step();
    step();
    s_if.bitstream_read = 1'b1;
    step();
    s_if.bitstream_read = 1'b0;
  endtask

  task automatic stream_range(input string tag, input int first, input int last,
                              input int alt_idx, input logic [23:0] alt_val);
    logic [23:0] w;
    logic [23:0] e;
    bit          ok;
    for (int i = first; i <= last; i++) begin
      consume_word($sformatf("%s_w%0d", tag, i), w, ok);
      if (!ok) return;
      e = (i == alt_idx) ? alt_val : exp_word(i);
      check($sformatf("%s_w%0d", tag, i), w, e);
    end
  endtask

  initial begin
    logic [23:0] w0;
    logic [23:0] tear_exp;
    bit          stable;
    bit          ok;
    int          fd0;
    int          ov0;
    int          st0;

    resetn              = 1'b0;
    wr_en               = 1'b0;
    wr_addr             = '0;
    wr_data             = '0;
    frame_tick          = 1'b0;
    s_if.bitstream_read = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_avail",      32'(s_if.bitstream_available), 32'd0);
    check("rst_bitstream",  32'(s_if.bitstream), 32'd0);
    check("rst_busy",       32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overrun",    32'(overrun), 32'd0);
    resetn = 1'b1;
    step();

    // Frame 1: latency, hold, ordered delivery
    load_all(-1);
    fd0 = fd_cnt;
    pulse_tick();                              // now in cycle T+1
    check("lat_t1_avail", 32'(s_if.bitstream_available), 32'd0);
    check("lat_t1_busy",  32'(busy), 32'd1);
    step();
    check("lat_t2_avail", 32'(s_if.bitstream_available), 32'd0);
    step();
    check("lat_t3_avail", 32'(s_if.bitstream_available), 32'd1);
    w0     = s_if.bitstream;
    stable = 1'b1;
    repeat (50) begin
      step();
      if (s_if.bitstream !== w0 || s_if.bitstream_available !== 1'b1) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'd1);
    check("f1_w0", 32'(w0), 32'(exp_word(0)));
    s_if.bitstream_read = 1'b1;
    step();                                    // cycle R+1
    s_if.bitstream_read = 1'b0;
    check("avail_drop", 32'(s_if.bitstream_available), 32'd0);
    step();
    check("rd_lat_r2_avail", 32'(s_if.bitstream_available), 32'd0);
    step();
    check("rd_lat_r3_avail", 32'(s_if.bitstream_available), 32'd1);
    check("word5_const", 32'(exp_word(5)), 32'h0005A5FA);
    stream_range("f1", 1, LEDCOUNT - 1, -1, 24'h0);
    check("f1_done_busy",  32'(busy), 32'd0);
    check("f1_done_pulse", 32'(frame_done), 32'd1);
    step();
    check("f1_done_low",   32'(frame_done), 32'd0);
    check("f1_done_count", 32'(fd_cnt - fd0), 32'd1);

    // A read pulse while nothing is available is ignored
    s_if.bitstream_read = 1'b1;
    step();
    s_if.bitstream_read = 1'b0;
    check("idle_read_busy",  32'(busy), 32'd0);
    check("idle_read_avail", 32'(s_if.bitstream_available), 32'd0);

    // Frame tick while streaming word 10
    load_all(-1);
    fd0 = fd_cnt;
    ov0 = ov_cnt;
    pulse_tick();
    stream_range("ov", 0, 9, -1, 24'h0);
    wait_avail("ov_w10", ok);
    pulse_tick();
    check("ov_pulse", 32'(overrun), 32'd1);
    stream_range("ov", 10, LEDCOUNT - 1, -1, 24'h0);
    st0 = start_cnt;
    repeat (10) step();
    check("ov_count",     32'(ov_cnt - ov0), 32'd1);
    check("ov_fd_count",  32'(fd_cnt - fd0), 32'd1);
    check("ov_no_restart", 32'(start_cnt - st0), 32'd0);
    check("ov_idle_busy", 32'(busy), 32'd0);

    // Reset while streaming word 20
    load_all(-1);
    fd0 = fd_cnt;
    pulse_tick();
    stream_range("rs", 0, 19, -1, 24'h0);
    wait_avail("rs_w20", ok);
    check("rs_w20_pre", 32'(s_if.bitstream), 32'(exp_word(20)));
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("rs_avail",      32'(s_if.bitstream_available), 32'd0);
    check("rs_busy",       32'(busy), 32'd0);
    check("rs_frame_done", 32'(frame_done), 32'd0);
    repeat (3) step();
    check("rs_fd_count",   32'(fd_cnt - fd0), 32'd0);
    pulse_tick();
    stream_range("rs2", 0, LEDCOUNT - 1, -1, 24'h0);
    step();

    // Out-of-range write is ignored
    load_all(-1);
    write_word(40, 24'hFFFFFF);
    pulse_tick();
    stream_range("oor", 0, LEDCOUNT - 1, -1, 24'h0);
    step();

    // Write LED 30 while word 3 streams
    load_all(-1);
    pulse_tick();
    stream_range("tear", 0, 2, -1, 24'h0);
    wait_avail("tear_w3", ok);
    write_word(30, 24'h123456);
`ifdef WS2812B_FRAME_STREAMER_DOUBLE_BUFFER_EN
    tear_exp = exp_word(30);
`else
    tear_exp = 24'h123456;
`endif
    stream_range("tear", 3, LEDCOUNT - 1, 30, tear_exp);
    step();

    // Next frame shows the mid-frame write to LED 30
    load_all(30);
    pulse_tick();
    stream_range("next", 0, LEDCOUNT - 1, 30, 24'h123456);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/ws2812b_frame_streamer.md
Name: ws2812b_frame_streamer

Overview:
- Frame store plus sequencer that sits directly upstream of the WS2812B serializer (ws2812b_out_module).
- Holds one 24-bit GRB word per LED, written from the SPI/control side.
- On each frame tick, streams all words in LED order over the bitstream_available/bitstream/bitstream_read handshake.
- Replaces the ad-hoc 1-bit-per-colour rotate registers in the top level with full 8-bit-per-channel colour.

Parameters:
- LEDCOUNT, 36, number of LEDs in the chain; legal range 1..2**ADDR_WIDTH.
- ADDR_WIDTH, 6, width of the write address and the internal LED index.

Ports:
- clk  in  1  system clock (9 MHz PLL clock).
- resetn  in  1  reset.
- wr_en  in  1  write strobe for frame memory, one word per cycle.
- wr_addr  in  ADDR_WIDTH  LED index to write; values >= LEDCOUNT are ignored.
- wr_data  in  24  GRB word: [23:16] green, [15:8] red, [7:0] blue; bit 23 is sent first.
- frame_tick  in  1  one-cycle request to start streaming a frame.
- bitstream_available  out  1  bitstream holds a valid word not yet consumed.
- bitstream  out  24  current GRB word to the serializer.
- bitstream_read  in  1  one-cycle pulse from the serializer: word taken.
- busy  out  1  high from frame start until the last word is consumed.
- frame_done  out  1  one-cycle pulse after the last word is consumed.
- overrun  out  1  one-cycle pulse when frame_tick arrives while busy.

Behaviour:
- Reset (already decided): clock clk; reset resetn, synchronous, active-low.
- Reset values: bitstream_available=0, bitstream=0, busy=0, frame_done=0, overrun=0, state=IDLE, index=0.
- Frame memory is not cleared by reset. Contents are undefined after power-up until written.
- Memory: LEDCOUNT x 24 bits, synchronous read, one read and one write port, single clk.
- Same-address read/write in one cycle returns the old data (read-before-write).
- Writes are accepted in every state, including during reset deassertion.
- States:
  - IDLE: busy=0. On frame_tick go to FETCH with index=0; busy=1 from the next cycle.
  - FETCH: issue read at index, go to LOAD.
  - LOAD: register the read data into bitstream, set bitstream_available=1, go to PRESENT.
  - PRESENT: bitstream and bitstream_available are held stable until bitstream_read=1. On that cycle:
    - bitstream_available=0 next cycle.
    - If index==LEDCOUNT-1: go to IDLE, pulse frame_done, busy=0 next cycle.
    - Else: index+1, go to FETCH.
- Latency:
  - frame_tick at cycle T gives bitstream_available=1 at T+3.
  - bitstream_read at cycle R gives the next word available at R+3.
- bitstream_read while bitstream_available=0 is ignored.
- frame_tick while busy:
  - The tick is dropped and overrun pulses for one cycle.
  - The frame in progress is unaffected.
  - A tick in the same cycle that frame_done pulses counts as busy.
- Index arithmetic is ADDR_WIDTH bits. It never wraps past LEDCOUNT-1, so the LEDCOUNT=2**ADDR_WIDTH case must compare against LEDCOUNT-1, not LEDCOUNT.
- Reset mid-frame: state returns to IDLE next cycle and bitstream_available drops; no frame_done pulse. The serializer is reset by the same signal.
- No inter-frame latch gap is generated here; the frame_tick period provides it.

Optional Feature:
- Macro: WS2812B_FRAME_STREAMER_DOUBLE_BUFFER_EN.
- With the macro: two banks.
  - Writes always go to the back bank.
  - Streaming reads the front bank.
  - On an accepted frame_tick in IDLE the banks swap in the same cycle, before the first FETCH.
  - A frame therefore streams exactly the data written before its tick. Writes during streaming never tear the frame.
  - Dropped ticks do not swap.
- Without the macro: single bank. Writes are visible to any word not yet fetched in the current frame, so tearing is possible and accepted.

Test Plan:
- Write LED i = {i, 8'hA5, ~i} for i=0..35, pulse frame_tick, serializer model asserts bitstream_read 2 cycles after each available:
  - 36 words appear in order, word 5 = 24'h05A5FA.
  - frame_done pulses once after word 35; busy low next cycle.
- frame_tick at T:
  - bitstream_available rises exactly at T+3.
  - bitstream stays constant for 50 cycles of withheld bitstream_read.
  - Available drops one cycle after the read pulse.
- frame_tick pulsed while streaming word 10:
  - overrun pulses once.
  - All 36 words still delivered, then IDLE.
  - No second frame starts.
- Assert resetn=0 while streaming word 20:
  - Next cycle bitstream_available=0, busy=0, no frame_done.
  - A new frame_tick restarts at word 0 with the memory contents intact.
- Write to wr_addr=40 (value 24'hFFFFFF) then stream: the 36 delivered words are unchanged.
- Write LED 30 = 24'h123456 mid-frame while word 3 streams:
  - Without the macro: word 30 = 24'h123456.
  - With WS2812B_FRAME_STREAMER_DOUBLE_BUFFER_EN: word 30 keeps its old value; the next frame shows 24'h123456.
